pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 28 ++
 rtl/pc_fetch.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared fetch-stage constants, FSM encoding and address helpers
package pc_fetch_pkg;

   // Architectural reset vector and the canonical NOP (addi x0, x0, 0).
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   // Fixed instruction width in bytes; the PC advances by this amount.
   localparam logic [31:0] PC_STEP = 32'd4;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_HOLD  = 2'd2
   } fetch_state_e;

   // A redirect target is only legal on a 32-bit word boundary.
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

   // Sequential next PC; the 32-bit add wraps naturally at the top of memory.
   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC sequencing, imem handshake, redirect handling
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_src1,
   input  logic [31:0] target_addr,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic        misalign_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic         valid_q, valid_d;
   logic         misalign_q, misalign_d;
   logic         pend_q, pend_d;
   logic [31:0]  pend_addr_q, pend_addr_d;

   logic         redirect_ok;
   logic         redirect_bad;

   // Classify the incoming redirect once; a misaligned target is dropped
   // and only reported, it never disturbs the sequencer.
   assign redirect_ok  = pc_src1 &&  is_word_aligned(target_addr);
   assign redirect_bad = pc_src1 && !is_word_aligned(target_addr);

   // The request is a pure decode of the state so it drops the instant reset
   // asserts; the address is the PC register, which only moves on an ack or
   // outside FETCH, keeping it stable for the memory.
   assign imem_req     = (state_q == FS_FETCH);
   assign imem_addr    = pc_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign instr_valid  = valid_q;
   assign misalign_err = misalign_q;

   // State, PC, held-instruction and pending-redirect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FS_IDLE;
         pc_q        <= RESET_PC;
         instr_q     <= NOP_INSTR;
         instr_pc_q  <= 32'h0000_0000;
         valid_q     <= 1'b0;
         misalign_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         instr_pc_q  <= instr_pc_d;
         valid_q     <= valid_d;
         misalign_q  <= misalign_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   // Next-state logic: IDLE -> FETCH -> HOLD -> FETCH ..., with redirects
   // either applied at once or parked until the outstanding request returns.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      valid_d     = valid_q;
      misalign_d  = redirect_bad;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;

      unique case (state_q)
         FS_IDLE: begin
            if (redirect_ok) begin
               pc_d    = target_addr;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
            state_d = FS_FETCH;
         end

         FS_FETCH: begin
            if (!imem_ack) begin
               // The request cannot be withdrawn; remember where to go once
               // it completes. A later redirect simply replaces the earlier.
               if (redirect_ok) begin
                  pend_d      = 1'b1;
                  pend_addr_d = target_addr;
               end
            end else if (redirect_ok) begin
               // Coincident redirect wins over anything parked.
               pc_d   = target_addr;
               pend_d = 1'b0;
            end else if (pend_q) begin
               // Returned word belongs to the abandoned path: drop it.
               pc_d   = pend_addr_q;
               pend_d = 1'b0;
            end else begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_incr(pc_q);
               state_d    = FS_HOLD;
            end
         end

         FS_HOLD: begin
            if (redirect_ok) begin
               // Redirect flushes the held instruction even under stall.
               pc_d    = target_addr;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               state_d = FS_FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               state_d = FS_FETCH;
            end
         end

         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

endmodule
